// File: rtl/add_arbiter_if.sv
// -----------------------------------------------------------------------------
// add_arbiter_if
// Purpose : Bundles the two requester handshakes and the result channel of the
//           shared-adder arbiter into one interface.
// Signals :
//   req0_valid/req0_ready/req0_a/req0_b : requester 0 operand handshake
//   req1_valid/req1_ready/req1_a/req1_b : requester 1 operand handshake
//   res_valid/res_ready                 : result handshake (consumer backpressure)
//   res_sum/res_carry/res_src           : registered sum, carry-out, source tag
// Modports:
//   slave  : the arbiter side (drives readies and result)
//   master : the requester/consumer side (drives valids, operands, res_ready)
// -----------------------------------------------------------------------------
interface add_arbiter_if #(
    parameter int unsigned W = 8
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;

    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_carry;
    logic         res_src;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_sum, res_carry, res_src
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_sum, res_carry, res_src
    );
endinterface

// File: rtl/add_arbiter.sv
// -----------------------------------------------------------------------------
// add_arbiter
// Purpose : Two-port round-robin arbiter and sequencer in front of a shared
//           W-bit adder. One requester is granted at a time; its operands are
//           latched, added in a single EXEC cycle, and the registered sum,
//           carry and source tag are presented on a valid/ready result channel.
// Ports   :
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   ena    in   gates acceptance of new requests only
//   busy   out  high while executing or holding a result
//   bus    slave modport of add_arbiter_if (request and result handshakes)
// Config  :
//   ADDARB_SAT_EN  when defined, res_sum saturates to all-ones on overflow;
//                  res_carry still reports the raw carry. Otherwise res_sum
//                  wraps modulo 2^W.
// -----------------------------------------------------------------------------
module add_arbiter #(
    parameter int unsigned W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    output logic          busy,
    add_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_q, state_d;

    logic         last_src_q;
    logic         pend_src_q;
    logic [W-1:0] op_a_q;
    logic [W-1:0] op_b_q;

    logic [W-1:0] sum_q;
    logic         carry_q;
    logic         src_q;

    logic         window;
    logic         grant0;
    logic         grant1;
    logic         handshake;

    logic [W:0]   sum_full;
    logic [W-1:0] sum_out;

    // ------------------------------------------------------------------
    // Acceptance window and arbitration (combinational from the valids).
    // rst_n is folded in so both readies read 0 while reset is held.
    // ------------------------------------------------------------------
    always_comb begin
        window = 1'b0;
        if (rst_n && ena) begin
            if (state_q == IDLE)
                window = 1'b1;
            else if (state_q == RESP && bus.res_ready)
                window = 1'b1;
        end
    end

    // On a tie, the port that did not win last time is granted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (window) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_src_q;
                grant1 = ~last_src_q;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign handshake      = grant0 | grant1;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (handshake)
                    state_d = EXEC;
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (bus.res_ready)
                    state_d = handshake ? EXEC : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture at the handshake edge only.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q     <= '0;
            op_b_q     <= '0;
            pend_src_q <= 1'b0;
            last_src_q <= 1'b1;
        end else if (handshake) begin
            op_a_q     <= grant1 ? bus.req1_a : bus.req0_a;
            op_b_q     <= grant1 ? bus.req1_b : bus.req0_b;
            pend_src_q <= grant1;
            last_src_q <= grant1;
        end
    end

    // ------------------------------------------------------------------
    // Adder: only the latched operands feed it, so there is no path from
    // the request operands to the result outputs.
    // ------------------------------------------------------------------
    assign sum_full = {1'b0, op_a_q} + {1'b0, op_b_q};

`ifdef ADDARB_SAT_EN
    assign sum_out = sum_full[W] ? '1 : sum_full[W-1:0];
`else
    assign sum_out = sum_full[W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            src_q   <= 1'b0;
        end else if (state_q == EXEC) begin
            sum_q   <= sum_out;
            carry_q <= sum_full[W];
            src_q   <= pend_src_q;
        end
    end

    assign bus.res_valid = (state_q == RESP);
    assign bus.res_sum   = sum_q;
    assign bus.res_carry = carry_q;
    assign bus.res_src   = src_q;
    assign busy          = (state_q == EXEC) || (state_q == RESP);

endmodule

// File: tb/tb_add_arbiter.sv
// -----------------------------------------------------------------------------
// tb_add_arbiter
// Self-checking bench for add_arbiter. A behavioural model (an in-flight
// operation slot plus a held-result slot) predicts readies and result outputs
// every cycle; directed sequences pin literal values, then random traffic runs.
// -----------------------------------------------------------------------------
module tb_add_arbiter;

    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    logic ena;
    logic busy;

    add_arbiter_if #(.W(W)) bus ();

    add_arbiter #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .busy  (busy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    bit          m_inflight = 1'b0;   // operation accepted, result next cycle
    bit          m_have_res = 1'b0;   // result currently presented
    bit          m_last     = 1'b1;
    logic [W-1:0] m_op_a = '0, m_op_b = '0;
    bit          m_op_src = 1'b0;
    logic [W-1:0] m_sum   = '0;
    bit          m_carry  = 1'b0;
    bit          m_src    = 1'b0;

    function automatic bit exp_win();
        return ena && !m_inflight && (!m_have_res || bus.res_ready);
    endfunction

    function automatic bit exp_rdy0();
        return exp_win() && bus.req0_valid && (!bus.req1_valid || m_last);
    endfunction

    function automatic bit exp_rdy1();
        return exp_win() && bus.req1_valid && (!bus.req0_valid || !m_last);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_inflight = 1'b0;
            m_have_res = 1'b0;
            m_last     = 1'b1;
            m_sum      = '0;
            m_carry    = 1'b0;
            m_src      = 1'b0;
        end else begin
            bit g0, g1;
            int unsigned s;
            g0 = exp_rdy0();
            g1 = exp_rdy1();
            if (m_inflight) begin
                s = int'(m_op_a) + int'(m_op_b);
                m_carry = (s > 255);
`ifdef ADDARB_SAT_EN
                m_sum = (s > 255) ? 8'hFF : s[7:0];
`else
                m_sum = s[7:0];
`endif
                m_src      = m_op_src;
                m_have_res = 1'b1;
                m_inflight = 1'b0;
            end else if (m_have_res && bus.res_ready) begin
                m_have_res = 1'b0;
            end
            if (g0 || g1) begin
                m_inflight = 1'b1;
                m_op_a     = g1 ? bus.req1_a : bus.req0_a;
                m_op_b     = g1 ? bus.req1_b : bus.req0_b;
                m_op_src   = g1;
                m_last     = g1;
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rdy0",  {31'b0, bus.req0_ready}, 0);
            chk("rst_rdy1",  {31'b0, bus.req1_ready}, 0);
            chk("rst_valid", {31'b0, bus.res_valid},  0);
            chk("rst_busy",  {31'b0, busy},           0);
        end else begin
            chk("m_rdy0",  {31'b0, bus.req0_ready}, {31'b0, exp_rdy0()});
            chk("m_rdy1",  {31'b0, bus.req1_ready}, {31'b0, exp_rdy1()});
            chk("m_valid", {31'b0, bus.res_valid},  {31'b0, m_have_res});
            chk("m_busy",  {31'b0, busy},           {31'b0, (m_inflight || m_have_res)});
            if (m_have_res) begin
                chk("m_sum",   {24'b0, bus.res_sum},   {24'b0, m_sum});
                chk("m_carry", {31'b0, bus.res_carry}, {31'b0, m_carry});
                chk("m_src",   {31'b0, bus.res_src},   {31'b0, m_src});
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_a = '0; bus.req1_b = '0;
        bus.res_ready = 1'b1;
        ena = 1'b1;
    endtask

    int grants[$];
    logic [W-1:0] held_sum;
    bit held_src;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_valid", {31'b0, bus.res_valid}, 0);
        chk("reset_busy",  {31'b0, busy}, 0);

        // Single request
        tick();
        bus.req0_valid = 1'b1; bus.req0_a = 8'h12; bus.req0_b = 8'h34;
        @(negedge clk);
        chk("single_rdy0", {31'b0, bus.req0_ready}, 1);
        tick();                                   // EXEC
        bus.req0_valid = 1'b0; bus.req0_a = 8'hFF; bus.req0_b = 8'hFF;
        bus.res_ready = 1'b0;
        @(negedge clk);
        chk("single_exec_valid", {31'b0, bus.res_valid}, 0);
        tick();                                   // RESP
        @(negedge clk);
        chk("single_valid", {31'b0, bus.res_valid}, 1);
        chk("single_sum",   {24'b0, bus.res_sum}, 32'h46);
        chk("single_carry", {31'b0, bus.res_carry}, 0);
        chk("single_src",   {31'b0, bus.res_src}, 0);

        // Asynchronous reset during RESP
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("async_valid", {31'b0, bus.res_valid}, 0);
        chk("async_sum",   {24'b0, bus.res_sum}, 0);
        chk("async_busy",  {31'b0, busy}, 0);
        bus.req0_valid = 1'b1; bus.req0_a = 8'h01; bus.req0_b = 8'h02;
        bus.req1_valid = 1'b1; bus.req1_a = 8'h05; bus.req1_b = 8'h06;
        bus.res_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("tie_rdy0", {31'b0, bus.req0_ready}, 1);
        chk("tie_rdy1", {31'b0, bus.req1_ready}, 0);

        // Overflow from requester 1
        tick();                                   // EXEC of 1+2
        bus.req0_valid = 1'b0;
        bus.req1_a = 8'hF0; bus.req1_b = 8'h20;
        tick();                                   // RESP of 1+2
        @(negedge clk);
        chk("ovf_prev_sum", {24'b0, bus.res_sum}, 32'h03);
        chk("ovf_rdy1",     {31'b0, bus.req1_ready}, 1);
        tick();                                   // EXEC
        bus.req1_valid = 1'b0;
        tick();                                   // RESP
        @(negedge clk);
`ifdef ADDARB_SAT_EN
        chk("ovf_sum", {24'b0, bus.res_sum}, 32'hFF);
`else
        chk("ovf_sum", {24'b0, bus.res_sum}, 32'h10);
`endif
        chk("ovf_carry", {31'b0, bus.res_carry}, 1);
        chk("ovf_src",   {31'b0, bus.res_src}, 1);

        // Contention from reset
        tick();
        rst_n = 1'b0;
        tick();
        bus.req0_valid = 1'b1; bus.req0_a = 8'h10; bus.req0_b = 8'h01;
        bus.req1_valid = 1'b1; bus.req1_a = 8'h20; bus.req1_b = 8'h02;
        bus.res_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.req0_ready) grants.push_back(0);
            if (bus.req1_ready) grants.push_back(1);
            chk("cont_valid", {31'b0, bus.res_valid}, {31'b0, (i >= 2 && i % 2 == 0)});
            tick();
        end
        chk("cont_ngrants", grants.size(), 6);
        for (int i = 0; i < 4; i++)
            chk("cont_grant", (i < grants.size()) ? grants[i] : -1, i % 2);

        // Backpressure in RESP with both valid
        bus.res_ready = 1'b0;
        @(negedge clk);
        held_sum = bus.res_sum;
        held_src = bus.res_src;
        chk("bp_held_src", {31'b0, held_src}, 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_rdy0",  {31'b0, bus.req0_ready}, 0);
            chk("bp_rdy1",  {31'b0, bus.req1_ready}, 0);
            chk("bp_valid", {31'b0, bus.res_valid}, 1);
            chk("bp_sum",   {24'b0, bus.res_sum}, {24'b0, held_sum});
            tick();
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy0", {31'b0, bus.req0_ready}, 1);

        // Gating with ena=0
        tick();                                   // EXEC
        ena = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("gate_exec_busy", {31'b0, busy}, 1);
        chk("gate_rdy0_a",    {31'b0, bus.req0_ready}, 0);
        tick();                                   // RESP
        @(negedge clk);
        chk("gate_resp_valid", {31'b0, bus.res_valid}, 1);
        chk("gate_resp_sum",   {24'b0, bus.res_sum}, 32'h11);
        chk("gate_rdy0_b",     {31'b0, bus.req0_ready}, 0);
        tick();                                   // IDLE
        @(negedge clk);
        chk("gate_idle_busy", {31'b0, busy}, 0);
        chk("gate_rdy0_c",    {31'b0, bus.req0_ready}, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            ena            = ($urandom_range(0, 3) != 0);
            bus.req0_valid = $urandom_range(0, 1);
            bus.req1_valid = $urandom_range(0, 1);
            bus.req0_a     = W'($urandom);
            bus.req0_b     = W'($urandom);
            bus.req1_a     = W'($urandom);
            bus.req1_b     = W'($urandom);
            bus.res_ready  = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
# add_arbiter

Two-port round-robin arbiter and sequencer for the shared W-bit adder datapath in the top-level design. Each of two requesters presents an operand pair over a valid/ready handshake. The block grants one requester at a time, registers the sum and carry, and returns them with a source tag over a valid/ready result channel with backpressure. It lets two producers share one adder without contention.

## Interface
- W, default 8: operand and sum width.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  gates acceptance of new requests only.
- req0_valid  in  1  requester 0 holds an operand pair.
- req0_ready  out  1  requester 0 handshake accepted this cycle.
- req0_a, req0_b  in  W  requester 0 operands.
- req1_valid, req1_ready, req1_a, req1_b: same set for requester 1.
- res_valid  out  1  result held and valid.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  W  registered sum.
- res_carry  out  1  registered carry-out of the W-bit add.
- res_src  out  1  requester that produced the current result.
- busy  out  1  high in states EXEC and RESP.

## Operation
- States: IDLE, EXEC, RESP.
- Acceptance window: state is IDLE, or state is RESP with res_ready=1. In both cases ena must be 1.
- Arbitration inside the window:
  - Only one reqN_valid high: that port is granted.
  - Both high: the port differing from last_src is granted.
  - reqN_ready=1 only for the granted port, and it is combinational from the valids.
- On a handshake (valid&ready):
  - Operands latch into internal registers.
  - last_src and a pending source tag update.
  - Next state is EXEC.
- EXEC, exactly one cycle:
  - The (W+1)-bit sum of the latched operands is computed.
  - res_sum takes the low W bits, res_carry the MSB, res_src the pending tag.
  - Next state is RESP.
- RESP:
  - res_valid=1; res_sum, res_carry and res_src are held stable.
  - res_ready=1 with a handshake: next state EXEC.
  - res_ready=1 without a handshake: next state IDLE.
  - res_ready=0: state stays RESP and both reqN_ready stay 0.
- ena=0: both reqN_ready are 0. EXEC and RESP still progress normally.
- Arithmetic: unsigned, operands zero-extended to W+1 bits.
- Operands are sampled only at the handshake edge. Changes after the handshake do not affect the result.
- Reset, asynchronous and applicable mid-operation:
  - State returns to IDLE and last_src=1, so port 0 wins the first tie.
  - Outputs go to res_valid=0, res_sum=0, res_carry=0, res_src=0 and busy=0.
  - req0_ready and req1_ready go to 0.
  - Any in-flight operation is discarded.

## Timing
- Handshake in cycle t: EXEC in t+1, res_valid=1 from t+2.
- Latency from handshake to res_valid is 2 cycles.
- Peak throughput is one result per 2 cycles. This requires res_ready high and a request valid during every RESP cycle.
- res_valid drops in the cycle after the result handshake, unless that cycle is EXEC of the next operation; then it drops there too.
- res_valid is never high in EXEC.
- No combinational path from the request operands to the result outputs.
- reqN_ready depends combinationally on req0_valid, req1_valid, ena, state and res_ready.

## Configuration
- ADDARB_SAT_EN defined:
  - res_sum saturates to all-ones when the (W+1)-bit sum exceeds 2^W−1.
  - res_carry still reports the raw carry.
- ADDARB_SAT_EN undefined: res_sum wraps modulo 2^W.

## Test plan
- Reset: assert rst_n=0 during RESP with res_sum=0x46.
  - Required: res_valid, res_sum and busy are 0 immediately, without waiting for a clock edge.
  - Required: after release, the first tie grants port 0.
- Single request: req0 a=0x12, b=0x34, res_ready=1.
  - Required: res_valid at handshake+2 with res_sum=0x46, res_carry=0, res_src=0.
- Overflow: req1 a=0xF0, b=0x20.
  - Without the macro: res_sum=0x10, res_carry=1, res_src=1.
  - With ADDARB_SAT_EN: res_sum=0xFF, res_carry=1.
- Contention: both valid continuously from reset, res_ready=1.
  - Required: grants alternate 0,1,0,1 and one result appears every 2 cycles.
- Backpressure: res_ready=0 for 5 cycles during RESP while both requesters are valid.
  - Required: result outputs held stable and both reqN_ready=0 throughout.
  - Required: when res_ready rises, the next request is accepted in that same cycle.
- Gating: ena=0 with req0_valid=1.
  - Required: no handshake occurs.
  - Required: an operation already in EXEC still completes to RESP and delivers its result.
